// File: rtl/j1_io_uart_pkg.sv
// j1_io_pkg: address map, status bit positions and UART state types for the J1 I/O block
package j1_io_pkg;
    localparam logic [15:0] IO_UART_DATA = 16'h1000;
    localparam logic [15:0] IO_UART_STAT = 16'h2000;
    localparam logic [15:0] IO_LEDS      = 16'h4000;
    localparam logic [15:0] IO_CYCLES    = 16'h8000;
    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_TX_BUSY    = 4;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/j1_io_uart_if.sv
// j1_io_uart_if: J1 CPU I/O bus (strobes, address, write data, read data)
interface j1_io_uart_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] io_addr;
    logic             io_wr;
    logic             io_rd;
    logic [WIDTH-1:0] io_dout;
    logic [WIDTH-1:0] io_din;
    modport master (output io_addr, io_wr, io_rd, io_dout, input io_din);
    modport slave (input io_addr, io_wr, io_rd, io_dout, output io_din);
endinterface

// File: rtl/j1_io_uart_fifo.sv
// io_fifo: synchronous FIFO; a push into a full FIFO is accepted when a pop frees the slot in the same cycle
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rp];
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            rp <= '0;
            wp <= '0;
            cnt <= '0;
        end else begin
            rp <= rp + AW'(do_pop);
            wp <= wp + AW'(do_push);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/j1_io_uart.sv
// j1_io_uart: J1 I/O-bus peripheral with 8N1 UART, LED register and free-running cycle counter
module j1_io_uart import j1_io_pkg::*; #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         resetq,
    j1_io_uart_if.slave  bus,
    input  logic         uart_rx,
    output logic         uart_tx,
    output logic [7:0]   leds
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    logic sel_data, sel_stat, sel_leds, sel_cyc;
    logic tx_push, tx_pop, tx_full, tx_empty, tx_tick;
    logic rx_push, rx_pop, rx_full, rx_empty, rx_tick, rx_mid, rx_sample;
    logic ovr_set, ferr_set, stat_clr, rx_overrun, frame_err;
    logic rx_s1, rx_s2, rx_hold;
    logic [7:0] tx_head, rx_head, tx_shift, rx_shift;
    logic [2:0] tx_bit, rx_bit;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [WIDTH-1:0] cycles, stat;
    logic unused_hi;
    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    assign sel_data = bus.io_addr == IO_UART_DATA;
    assign sel_stat = bus.io_addr == IO_UART_STAT;
    assign sel_leds = bus.io_addr == IO_LEDS;
    assign sel_cyc = bus.io_addr == IO_CYCLES;
    assign tx_push = bus.io_wr && sel_data;
    assign rx_pop = bus.io_rd && sel_data;
    assign stat_clr = bus.io_rd && sel_stat;
    assign unused_hi = ^bus.io_dout[WIDTH-1:8];
    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetq(resetq), .push(tx_push), .pop(tx_pop), .din(bus.io_dout[7:0]),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );
    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetq(resetq), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            leds <= '0;
            cycles <= '0;
            rx_overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cycles <= cycles + WIDTH'(1);
            if (bus.io_wr && sel_leds) leds <= bus.io_dout[7:0];
            rx_overrun <= ovr_set || (rx_overrun && !stat_clr);
            frame_err <= ferr_set || (frame_err && !stat_clr);
        end
    assign tx_tick = tx_cnt == BIT_END;
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) tx_state <= TX_IDLE;
        else tx_state <= tx_next;
    always_comb
        tx_next = tx_state == TX_IDLE  ? (tx_empty ? TX_IDLE : TX_START)
                : !tx_tick             ? tx_state
                : tx_state == TX_START ? TX_DATA
                : tx_state == TX_DATA  ? (tx_bit == 3'd7 ? TX_STOP : TX_DATA)
                :                        TX_IDLE;
    always_comb begin
        tx_pop = tx_state == TX_IDLE && !tx_empty;
        uart_tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
    end
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_shift <= '0;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
            if (tx_pop) tx_shift <= tx_head;
            else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
        end
    assign rx_tick = rx_cnt == BIT_END;
    assign rx_mid = rx_cnt == HALF_END;
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) rx_state <= RX_IDLE;
        else rx_state <= rx_next;
    // after a bad stop bit, rx_hold keeps us in STOP until the line idles high
    always_comb
        rx_next = rx_state == RX_IDLE  ? (rx_s2 ? RX_IDLE : RX_START)
                : rx_state == RX_START ? (!rx_mid ? RX_START : rx_s2 ? RX_IDLE : RX_DATA)
                : rx_state == RX_DATA  ? (rx_tick && rx_bit == 3'd7 ? RX_STOP : RX_DATA)
                : (rx_hold || rx_tick) && rx_s2 ? RX_IDLE : RX_STOP;
    always_comb begin
        rx_sample = rx_state == RX_STOP && rx_tick && !rx_hold;
        rx_push = rx_sample && rx_s2;
        ferr_set = rx_sample && !rx_s2;
        ovr_set = rx_push && rx_full && !rx_pop;
    end
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_hold <= 1'b0;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_hold <= ferr_set || (rx_hold && !rx_s2);
            rx_cnt <= (rx_state == RX_IDLE || rx_next != rx_state || rx_tick) ? '0 : rx_cnt + CW'(1);
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
    always_comb begin
        stat = '0;
        stat[ST_TX_READY] = !tx_full;
        stat[ST_RX_VALID] = !rx_empty;
        stat[ST_RX_OVERRUN] = rx_overrun;
        stat[ST_FRAME_ERR] = frame_err;
        stat[ST_TX_BUSY] = tx_state != TX_IDLE || !tx_empty;
    end
    assign bus.io_din = sel_data ? {{(WIDTH-8){1'b0}}, rx_empty ? 8'h00 : rx_head}
                      : sel_stat ? stat
                      : sel_leds ? {{(WIDTH-8){1'b0}}, leds}
                      : sel_cyc  ? cycles
                      :            '0;
endmodule

// File: tb/tb_j1_io_uart.sv
// tb_j1_io_uart: register table, bit-exact frames and randomized serial traffic against a queue model
module tb_j1_io_uart;
    import j1_io_pkg::*;
    localparam int CPB = 4;
    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [15:0] dout;
        logic        chk;
        logic [15:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic [7:0] leds;
    logic mon_en = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_seen[$];
    logic [7:0] rx_exp[$];
    j1_io_uart_if #(.WIDTH(16)) bus();
    j1_io_uart #(.WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetq(resetq), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx), .leds(leds)
    );
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [15:0] exp_stat(input bit ready, input bit busy, input bit ovr, input bit ferr, input int rxn);
        return {11'b0, busy, ferr, ovr, rxn > 0, ready};
    endfunction
    task automatic bus_op(input logic [15:0] a, input logic w, input logic r, input logic [15:0] d, output logic [15:0] din);
        @(negedge clk);
        bus.io_addr = a;
        bus.io_wr = w;
        bus.io_rd = r;
        bus.io_dout = d;
        #1 din = bus.io_din;
        @(posedge clk);
        #1 bus.io_wr = 1'b0;
        bus.io_rd = 1'b0;
    endtask
    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        bus_op(a, 1'b0, 1'b1, 16'h0, d);
    endtask
    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] x;
        bus_op(a, 1'b1, 1'b0, d, x);
    endtask
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask
    task automatic wait_tx_idle(input string name);
        logic [15:0] s;
        int k;
        k = 0;
        do begin
            bus_rd(IO_UART_STAT, s);
            k++;
        end while (s[4] && k < 1000);
        check(name, 16'(s[4]), 16'h0);
    endtask
    task automatic cmp_tx(input string name);
        check({name, "_count"}, 16'(tx_seen.size()), 16'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 16'(tx_seen[i]), 16'(tx_exp[i]));
        tx_seen.delete();
        tx_exp.delete();
    endtask
    // serial decoder on uart_tx: samples mid-bit from the falling edge of the start bit
    initial forever begin
        @(negedge clk);
        if (mon_en && resetq && uart_tx === 1'b0) begin
            logic [7:0] mb;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mb[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check("tx_stop_bit", 16'(uart_tx), 16'h1);
            tx_seen.push_back(mb);
        end
    end
    initial begin
        vec_t tbl [13];
        logic [15:0] d, a;
        logic [7:0] b, led_m;
        logic [9:0] f;
        logic [3:0] samp;
        bit ovr, ferr;
        int w;
        tbl[0]  = '{IO_UART_DATA, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        tbl[1]  = '{IO_UART_STAT, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001};
        tbl[2]  = '{IO_LEDS,      1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        tbl[3]  = '{IO_LEDS,      1'b1, 1'b0, 16'h12A5, 1'b0, 16'h0000};
        tbl[4]  = '{IO_LEDS,      1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A5};
        tbl[5]  = '{IO_CYCLES,    1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
        tbl[6]  = '{16'h4001,     1'b1, 1'b0, 16'h0077, 1'b0, 16'h0000};
        tbl[7]  = '{IO_LEDS,      1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A5};
        tbl[8]  = '{16'h1234,     1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        tbl[9]  = '{16'h4001,     1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        tbl[10] = '{IO_LEDS,      1'b1, 1'b1, 16'h003C, 1'b1, 16'h00A5};
        tbl[11] = '{IO_LEDS,      1'b0, 1'b1, 16'h0000, 1'b1, 16'h003C};
        tbl[12] = '{IO_UART_STAT, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
        bus.io_addr = 16'h0;
        bus.io_wr = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_dout = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 16'(uart_tx), 16'h1);
        check("reset_leds", 16'(leds), 16'h0);
        resetq = 1'b1;
        bus.io_addr = IO_CYCLES;
        #1 check("cycles_at_release", bus.io_din, 16'h0);
        bus_rd(IO_CYCLES, d);
        check("cycles_1", d, 16'h1);
        bus_rd(IO_CYCLES, d);
        check("cycles_2", d, 16'h2);
        for (int i = 0; i < 13; i++) begin
            bus_op(tbl[i].addr, tbl[i].wr, tbl[i].rd, tbl[i].dout, d);
            if (tbl[i].chk) check($sformatf("vec%0d", i), d, tbl[i].exp);
        end
        check("leds_port", 16'(leds), 16'h003C);
        bus_rd(IO_UART_STAT, d);
        check("stat_after_ro_write", d, 16'h0001);
        // one frame, checked cycle by cycle
        bus_wr(IO_UART_DATA, 16'h00A5);
        tx_exp.push_back(8'hA5);
        bus_rd(IO_UART_STAT, d);
        check("stat_busy", d, exp_stat(1, 1, 0, 0, 0));
        w = 0;
        @(negedge clk);
        while (uart_tx && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("a5_start_seen", 16'(uart_tx), 16'h0);
        f = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < CPB; k++) begin
                samp[k] = uart_tx;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d", j), 16'(samp), f[j] ? 16'hF : 16'h0);
        end
        check("a5_line_idle", 16'(uart_tx), 16'h1);
        bus_rd(IO_UART_STAT, d);
        check("stat_idle", d, exp_stat(1, 0, 0, 0, 0));
        cmp_tx("a5");
        // burst of six: FIFO fills, the sixth byte is lost
        for (int i = 1; i <= 6; i++) bus_wr(IO_UART_DATA, 16'(i));
        bus_rd(IO_UART_STAT, d);
        check("stat_tx_full", d, exp_stat(0, 1, 0, 0, 0));
        for (int i = 1; i <= 5; i++) tx_exp.push_back(8'(i));
        wait_tx_idle("burst_drain");
        cmp_tx("burst");
        send_rx(8'h3C, 1'b1);
        bus_rd(IO_UART_STAT, d);
        check("stat_rx_valid", d, exp_stat(1, 0, 0, 0, 1));
        bus_rd(IO_UART_DATA, d);
        check("rx_3c", d, 16'h003C);
        bus_rd(IO_UART_STAT, d);
        check("stat_rx_popped", d, exp_stat(1, 0, 0, 0, 0));
        // overflow then a framing error
        ovr = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (rx_exp.size() < 4) rx_exp.push_back(b);
            else ovr = 1;
        end
        send_rx(8'($urandom), 1'b0);
        ferr = 1;
        bus_rd(IO_UART_STAT, d);
        check("stat_sticky", d, exp_stat(1, 0, ovr, ferr, rx_exp.size()));
        bus_rd(IO_UART_STAT, d);
        check("stat_cleared", d, exp_stat(1, 0, 0, 0, rx_exp.size()));
        while (rx_exp.size() > 0) begin
            bus_rd(IO_UART_DATA, d);
            check("rx_held", d, 16'(rx_exp.pop_front()));
        end
        bus_rd(IO_UART_STAT, d);
        check("stat_rx_drained", d, exp_stat(1, 0, 0, 0, 0));
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(IO_UART_STAT, d);
        check("glitch_stat", d, exp_stat(1, 0, 0, 0, 0));
        bus_rd(IO_UART_DATA, d);
        check("glitch_data", d, 16'h0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            bus_rd(IO_UART_DATA, d);
            check($sformatf("rnd_rx%0d", i), d, 16'(b));
        end
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            bus_wr(IO_UART_DATA, 16'(b));
            tx_exp.push_back(b);
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_tx_idle("rnd_drain");
        cmp_tx("rnd_tx");
        for (int i = 0; i < 6; i++) begin
            led_m = 8'($urandom);
            bus_wr(IO_LEDS, {8'($urandom), led_m});
            a = 16'($urandom);
            if (a == IO_UART_DATA || a == IO_UART_STAT || a == IO_LEDS || a == IO_CYCLES) a = 16'h0003;
            bus_rd(a, d);
            check($sformatf("rnd_unmapped%0d", i), d, 16'h0);
            bus_rd(IO_LEDS, d);
            check($sformatf("rnd_leds%0d", i), d, {8'h00, led_m});
            check($sformatf("rnd_leds_port%0d", i), 16'(leds), 16'(led_m));
        end
        // asynchronous reset in the middle of a start bit
        mon_en = 1'b0;
        bus_wr(IO_UART_DATA, 16'h0055);
        bus_wr(IO_UART_DATA, 16'h0066);
        bus_wr(IO_UART_DATA, 16'h0077);
        w = 0;
        @(negedge clk);
        while (uart_tx && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_low", 16'(uart_tx), 16'h0);
        #2 resetq = 1'b0;
        #1 check("reset_tx_async", 16'(uart_tx), 16'h1);
        bus.io_addr = IO_UART_STAT;
        #1 check("reset_stat", bus.io_din, exp_stat(1, 0, 0, 0, 0));
        check("reset_leds_async", 16'(leds), 16'h0);
        @(negedge clk);
        resetq = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_tx", 16'(uart_tx), 16'h1);
        bus_rd(IO_UART_STAT, d);
        check("post_reset_stat", d, exp_stat(1, 0, 0, 0, 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/j1_io_uart.md
Name: j1_io_uart

Overview:
- Memory-mapped I/O peripheral on the J1 CPU I/O bus. Consumes the CPU's io_wr/io_rd strobes, address and write data; returns read data to the CPU's io_din.
- Contains an 8N1 UART with 4-deep TX and RX FIFOs, an LED output register, and a free-running cycle counter.
- Sits directly downstream of the CPU core in the SoC top level.

Parameters:
- WIDTH, 16, data/address width; matches CPU `WIDTH.
- CLKS_PER_BIT, 104, clk cycles per UART bit; legal range ≥4.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of 2.

Ports:
- clk  in  1  system clock.
- resetq  in  1  reset, asynchronous, active-low.
- io_addr  in  WIDTH  I/O address; driven by the top level from the CPU's registered T.
- io_wr  in  1  write strobe; acts at the rising edge.
- io_rd  in  1  read strobe; side effects act at the rising edge.
- io_dout  in  WIDTH  write data (CPU N).
- io_din  out  WIDTH  read data; combinational from io_addr and registered state only.
- uart_rx  in  1  serial input; asynchronous to clk.
- uart_tx  out  1  serial output.
- leds  out  8  LED register.

Behaviour:
- Reset values: uart_tx=1, leds=0, FIFOs empty, cycle counter=0, sticky flags=0, TX and RX FSMs in IDLE.
- Register map uses exact address match. Unmapped reads return 0; unmapped writes are ignored.
- 0x1000 DATA:
  - Write pushes io_dout[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped silently.
  - Read returns {8'h00, RX head}, or 0 if RX is empty.
  - io_rd pops RX when it is non-empty.
- 0x2000 STATUS (read-only):
  - bit0 tx_ready = TX not full.
  - bit1 rx_valid = RX not empty.
  - bit2 rx_overrun, sticky.
  - bit3 frame_err, sticky.
  - bit4 tx_busy = TX FSM not IDLE or TX FIFO not empty.
  - Other bits are 0.
  - io_rd clears bits 2–3. If a set condition occurs in the same cycle as the clear, set wins.
- 0x4000 LEDS: write loads io_dout[7:0]; read returns {8'h00, leds}.
- 0x8000 CYCLES: read returns the counter, which increments every clk and wraps at 2^WIDTH. Writes are ignored.
- io_rd and io_wr asserted in the same cycle both take effect.
- A push and a pop on the same FIFO in the same cycle are both performed. This is legal even when the FIFO is full (TX) or empty (RX is not pushed from the bus).
- Data read latency: zero cycles (io_din is combinational). The pop takes effect at the same edge, so the next cycle shows the next entry.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE holds uart_tx=1. When TX is non-empty it pops the FIFO, latches the byte, and enters START on the next edge.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP drives 1 for CLKS_PER_BIT cycles, then returns to IDLE. A queued byte starts its start bit on the cycle after STOP ends plus the IDLE cycle.
- RX path: uart_rx passes through a 2-flop synchronizer. RX FSM: IDLE → START → DATA → STOP.
  - IDLE detects a synchronized low.
  - START waits CLKS_PER_BIT/2 cycles and resamples. If high, it returns to IDLE (glitch reject).
  - DATA samples 8 bits, CLKS_PER_BIT apart, LSB first.
  - STOP samples after CLKS_PER_BIT. If 1, push the byte; if RX is full, drop it and set rx_overrun. If 0, discard the byte, set frame_err, and return to IDLE only after a synchronized high.
- Asynchronous reset mid-frame: uart_tx returns to 1 immediately; any partial frame is lost.

Decomposition:
- Package j1_io_pkg holds:
  - address constants IO_UART_DATA=16'h1000, IO_UART_STAT=16'h2000, IO_LEDS=16'h4000, IO_CYCLES=16'h8000;
  - STATUS bit indices;
  - TX and RX state enum typedef.
- Sub-module io_fifo: synchronous FIFO (parameters WIDTH=8, DEPTH), with ports push/pop/din/dout/full/empty. It is instantiated twice, for TX and RX.
- UART FSMs stay in the top module.

Test Plan:
- Reset, then read all four registers with CLKS_PER_BIT=4 → DATA=0, STATUS=0x0001, LEDS=0, CYCLES counting from 0; uart_tx=1.
- Write 0x1000←0x00A5 → uart_tx reproduces 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles. STATUS bit4=1 during the frame and 0 afterwards.
- Write 6 bytes 0x01..0x06 back-to-back → tx_ready=0 once the FIFO is full. Bytes 0x01–0x05 are transmitted (0x01 is popped immediately, so the FIFO holds 4 more); 0x06 is dropped.
- Drive serial byte 0x3C on uart_rx → STATUS=0x0003. Reading DATA returns 0x003C, after which STATUS=0x0001.
- Send 5 RX bytes without reading, then a frame with stop=0 → STATUS bits 2,3 set and 4 bytes held. The first STATUS read returns 0x000F and the next returns 0x0003.
- Assert a 1-cycle low glitch on uart_rx → no byte pushed and no flags set. Assert resetq low mid-TX frame → uart_tx=1 immediately, FIFOs empty.
